uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one byte as start, 8 data bits LSB first,
// optional parity and one or two stop bits, paced by an external baud generator.
module uart_tx_ctrl #(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       baud_tick,
    output logic       baud_en,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

    localparam logic HAS_PARITY = (PARITY != 0);
    localparam logic ODD_PARITY = (PARITY == 2);
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic parity_of(input logic [7:0] data, input logic odd);
        parity_of = (^data) ^ odd;
    endfunction

    state_e     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       parity_q, parity_d;
    logic       tx_q, tx_d;
    logic       tx_ready_q, tx_ready_d;
    logic       baud_en_q, baud_en_d;
    logic       tx_busy_q, tx_busy_d;
    logic       tx_done_q, tx_done_d;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
        end
    end

    // Next-state and datapath update; ticks are only honoured outside IDLE
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        parity_d   = parity_q;
        case (state_q)
            S_IDLE: begin
                if (tx_valid && tx_ready_q) begin
                    state_d    = S_START;
                    shift_d    = tx_data;
                    bit_idx_d  = 3'd0;
                    stop_cnt_d = 1'b0;
                    parity_d   = parity_of(tx_data, ODD_PARITY);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = HAS_PARITY ? S_PARITY : S_STOP;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (baud_tick) begin
                    state_d    = S_STOP;
                    stop_cnt_d = 1'b0;
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == LAST_STOP) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state so every port is a flop
    always_comb begin
        tx_d       = 1'b1;
        tx_ready_d = 1'b0;
        baud_en_d  = 1'b1;
        tx_busy_d  = 1'b1;
        tx_done_d  = 1'b0;
        case (state_d)
            S_IDLE: begin
                tx_ready_d = 1'b1;
                baud_en_d  = 1'b0;
                tx_busy_d  = 1'b0;
                tx_done_d  = (state_q == S_STOP);
            end
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = parity_q;
            S_STOP:   tx_d = 1'b1;
            default: begin
                tx_d       = 1'b1;
                tx_ready_d = 1'b0;
                baud_en_d  = 1'b0;
                tx_busy_d  = 1'b0;
                tx_done_d  = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            baud_en_q  <= 1'b0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            baud_en_q  <= baud_en_d;
            tx_busy_q  <= tx_busy_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign tx       = tx_q;
    assign tx_ready = tx_ready_q;
    assign baud_en  = baud_en_q;
    assign tx_busy  = tx_busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised bench for uart_tx_ctrl: three parity/stop configurations run side by side,
// each against a tick-counting frame model and a byte scoreboard.
module tb_uart_tx_ctrl;

    localparam int DIV = 16;

    logic       clk;
    logic       reset_n;
    logic       tx_valid  [3];
    logic [7:0] tx_data   [3];
    logic       baud_tick [3];
    logic       tx_ready_w[3];
    logic       baud_en_w [3];
    logic       tx_w      [3];
    logic       tx_busy_w [3];
    logic       tx_done_w [3];

    uart_tx_ctrl #(.PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_w[0]), .baud_tick(baud_tick[0]), .baud_en(baud_en_w[0]),
        .tx(tx_w[0]), .tx_busy(tx_busy_w[0]), .tx_done(tx_done_w[0]));
    uart_tx_ctrl #(.PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_w[1]), .baud_tick(baud_tick[1]), .baud_en(baud_en_w[1]),
        .tx(tx_w[1]), .tx_busy(tx_busy_w[1]), .tx_done(tx_done_w[1]));
    uart_tx_ctrl #(.PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
        .tx_ready(tx_ready_w[2]), .baud_tick(baud_tick[2]), .baud_en(baud_en_w[2]),
        .tx(tx_w[2]), .tx_busy(tx_busy_w[2]), .tx_done(tx_done_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    logic stim_on;
    logic force_ff;

    // reference model and scoreboard state
    logic        m_idle [3];
    int          m_left [3];
    logic [11:0] m_bits [3];
    logic [7:0]  m_byte [3];
    logic [7:0]  exp_q  [3][$];
    logic [11:0] cap    [3];
    int          cap_n  [3];
    logic        prev_tx  [3];
    logic        prev_busy[3];
    int          frames [3];
    int          bcnt   [3];
    logic        valid_s[3];
    logic        tick_s [3];
    logic [7:0]  data_s [3];
    logic        rst_s;

    function automatic int par_of(input int k);
        return k;
    endfunction

    function automatic int sb_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction

    function automatic int flen(input int k);
        return 10 + ((par_of(k) != 0) ? 1 : 0) + (sb_of(k) - 1);
    endfunction

    // Line sequence in transmit order, bit 0 first; unused high positions read as 1.
    function automatic logic [11:0] frame_bits(input int k, input logic [7:0] d);
        logic [11:0] b;
        int ones;
        b = 12'hFFF;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[i+1] = d[i];
        ones = $countones(d);
        if (par_of(k) == 1) b[9] = ((ones % 2) == 1);
        if (par_of(k) == 2) b[9] = ((ones % 2) == 0);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic reinit_model();
        for (int k = 0; k < 3; k++) begin
            m_idle[k] = 1'b1;
            m_left[k] = 0;
            m_bits[k] = 12'hFFF;
            m_byte[k] = 8'h00;
            exp_q[k].delete();
            cap[k] = 12'h000;
            cap_n[k] = 0;
            prev_tx[k] = 1'b1;
            prev_busy[k] = 1'b0;
        end
    endtask

    task automatic stim_loop();
        logic [7:0] tab [6];
        tab[0] = 8'hA5; tab[1] = 8'h01; tab[2] = 8'h00;
        tab[3] = 8'hFF; tab[4] = 8'h55; tab[5] = 8'h0F;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!reset_n || !baud_en_w[k]) begin
                    bcnt[k] = 0;
                    baud_tick[k] = stim_on && ($urandom_range(0, 3) == 0);
                end else begin
                    bcnt[k] = bcnt[k] + 1;
                    if (bcnt[k] == DIV) begin
                        baud_tick[k] = 1'b1;
                        bcnt[k] = 0;
                    end else begin
                        baud_tick[k] = 1'b0;
                    end
                end
                tx_valid[k] = stim_on && ($urandom_range(0, 9) < 7);
                if (force_ff && k == 0) tx_data[k] = 8'hFF;
                else if ($urandom_range(0, 3) == 0) tx_data[k] = tab[$urandom_range(0, 5)];
                else tx_data[k] = 8'($urandom);
            end
        end
    endtask

    task automatic step(input int k);
        logic done_exp;
        logic exp_tx;
        logic [7:0] d;
        logic [11:0] mask;
        done_exp = 1'b0;
        if (!m_idle[k]) begin
            if (tick_s[k]) begin
                m_left[k] = m_left[k] - 1;
                if (m_left[k] == 0) begin
                    m_idle[k] = 1'b1;
                    done_exp = 1'b1;
                end
            end
        end else if (valid_s[k]) begin
            m_idle[k] = 1'b0;
            m_left[k] = flen(k);
            m_bits[k] = frame_bits(k, data_s[k]);
            m_byte[k] = data_s[k];
            exp_q[k].push_back(data_s[k]);
        end
        exp_tx = m_idle[k] ? 1'b1 : m_bits[k][flen(k) - m_left[k]];
        check($sformatf("cycle_outputs_dut%0d {tx,en,rdy,busy,done}", k),
              32'({tx_w[k], baud_en_w[k], tx_ready_w[k], tx_busy_w[k], tx_done_w[k]}),
              32'({exp_tx, !m_idle[k], m_idle[k], !m_idle[k], done_exp}));
        if (tick_s[k] && prev_busy[k] && cap_n[k] < 12) begin
            cap[k][cap_n[k]] = prev_tx[k];
            cap_n[k] = cap_n[k] + 1;
        end
        if (tx_done_w[k]) begin
            if (exp_q[k].size() == 0) begin
                check($sformatf("sb_unexpected_frame_dut%0d", k), 32'(cap_n[k]), 32'(0));
            end else begin
                d = exp_q[k].pop_front();
                mask = 12'hFFF >> (12 - flen(k));
                check($sformatf("sb_frame_bits_dut%0d byte %0h", k, d),
                      32'(cap[k]), 32'(frame_bits(k, d) & mask));
                check($sformatf("sb_frame_len_dut%0d", k), 32'(cap_n[k]), 32'(flen(k)));
                frames[k] = frames[k] + 1;
            end
            cap[k] = 12'h000;
            cap_n[k] = 0;
        end
        prev_tx[k] = tx_w[k];
        prev_busy[k] = tx_busy_w[k];
    endtask

    task automatic monitor_loop();
        forever begin
            @(posedge clk);
            rst_s = !reset_n;
            for (int k = 0; k < 3; k++) begin
                valid_s[k] = tx_valid[k] && reset_n;
                tick_s[k]  = baud_tick[k];
                data_s[k]  = tx_data[k];
            end
            @(negedge clk);
            if (rst_s || !reset_n) reinit_model();
            else for (int k = 0; k < 3; k++) step(k);
        end
    endtask

    initial begin
        logic found;
        logic all_idle;
        n_cmp = 0;
        n_fail = 0;
        stim_on = 1'b0;
        force_ff = 1'b0;
        reset_n = 1'b0;
        rst_s = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tx_valid[k] = 1'b0;
            tx_data[k] = 8'h00;
            baud_tick[k] = 1'b0;
            frames[k] = 0;
            bcnt[k] = 0;
            valid_s[k] = 1'b0;
            tick_s[k] = 1'b0;
            data_s[k] = 8'h00;
        end
        reinit_model();
        fork
            stim_loop();
            monitor_loop();
        join_none

        #12;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_state_dut%0d {tx,en,rdy,busy,done}", k),
                  32'({tx_w[k], baud_en_w[k], tx_ready_w[k], tx_busy_w[k], tx_done_w[k]}),
                  32'(5'b10100));
        stim_on = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3000) @(negedge clk);

        // abort a 0xFF frame on dut0 while data bit 3 is on the line
        force_ff = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(posedge clk);
            #2;
            if (!m_idle[0] && m_byte[0] == 8'hFF && (flen(0) - m_left[0]) == 4) found = 1'b1;
        end
        check("reset_target_reached", 32'(found), 32'(1));
        reset_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("async_reset_dut%0d {tx,en,rdy,busy,done}", k),
                  32'({tx_w[k], baud_en_w[k], tx_ready_w[k], tx_busy_w[k], tx_done_w[k]}),
                  32'(5'b10100));
        force_ff = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3000) @(negedge clk);

        stim_on = 1'b0;
        all_idle = 1'b0;
        for (int i = 0; i < 1000 && !all_idle; i++) begin
            @(negedge clk);
            all_idle = m_idle[0] && m_idle[1] && m_idle[2];
        end
        repeat (4) @(negedge clk);
        check("drain_within_budget", 32'(all_idle), 32'(1));
        for (int k = 0; k < 3; k++) begin
            check($sformatf("sb_empty_dut%0d", k), 32'(exp_q[k].size()), 32'(0));
            check($sformatf("frames_seen_dut%0d", k), 32'(frames[k] >= 3), 32'(1));
            check($sformatf("idle_line_dut%0d", k), 32'({tx_w[k], tx_ready_w[k]}), 32'(2'b11));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
